column_frame_reader: RTL

Double-buffered column store and pixel shader for the ray-cast renderer. The caster-side writer deposits one `{height, color}` result per screen column into the back bank. The VGA side reads the front bank at pixel rate and produces registered 4-bit RGB for ceiling, wall, floor and the shooting crosshair. Banks swap only at the start of vertical blanking, so a frame is never displayed while it is half-written.

---
 rtl/column_frame_reader_if.sv | 32 +++
 rtl/column_frame_reader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/column_frame_reader_if.sv
// Column writer and pixel-read bundle for column_frame_reader.
// master = caster writer / VGA timing side, slave = column_frame_reader.
// Write side: wr_en/wr_x/wr_height/wr_color/frame_done in, swap_pending/active_bank out.
// Read side: pix_stb/x/y/shooting in, vga_r/vga_g/vga_b out.
interface column_frame_reader_if;
  logic       wr_en;
  logic [8:0] wr_x;
  logic [7:0] wr_height;
  logic [3:0] wr_color;
  logic       frame_done;
  logic       swap_pending;
  logic       active_bank;
  logic       pix_stb;
  logic [9:0] x;
  logic [8:0] y;
  logic       shooting;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;

  modport master (
    output wr_en, wr_x, wr_height, wr_color, frame_done,
    output pix_stb, x, y, shooting,
    input  swap_pending, active_bank, vga_r, vga_g, vga_b
  );

  modport slave (
    input  wr_en, wr_x, wr_height, wr_color, frame_done,
    input  pix_stb, x, y, shooting,
    output swap_pending, active_bank, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/column_frame_reader.sv
// Double-buffered column store + pixel shader: writer fills the back bank,
// VGA side shades the front bank. Latency: RGB for the pixel sampled at strobe k
// is registered on strobe k+2. Backpressure: swap_pending high means writes are dropped.
// Ports: clk, rst_n (async active-low), bus (slave modport): column write,
// frame_done/swap_pending/active_bank bank control, pix_stb/x/y/shooting in, vga_* out.
module column_frame_reader #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic                 clk,
  input  logic                 rst_n,
  column_frame_reader_if.slave bus
);

  typedef struct packed {
    logic [3:0] color;
    logic [7:0] top;
    logic [7:0] bot;
  } col_t;

  localparam logic [8:0]  WR_LIM = 9'(WIDTH);
  localparam logic [9:0]  X_LIM  = 10'(WIDTH);
  localparam logic [8:0]  Y_LIM  = 9'(HEIGHT);
  localparam logic [7:0]  H_MAX  = 8'(HEIGHT);

  // Column storage is deliberately not reset; frame_valid hides stale contents.
  col_t bank_mem [2][WIDTH];

  logic swap_pending_q;
  logic active_bank_q;
  logic frame_valid_q;

  logic       swap_point;
  logic       swap_take;
  logic       wr_ok;
  logic [7:0] h_clamp;
  logic [7:0] wr_top;
  col_t       wr_ent;

  always_comb begin
    swap_point   = bus.pix_stb && (bus.x == 10'd0) && (bus.y == Y_LIM);
    // Only a request already pending before the swap point is honoured.
    swap_take    = swap_point && swap_pending_q;
    wr_ok        = bus.wr_en && (bus.wr_x < WR_LIM) && !swap_pending_q;
    h_clamp      = (bus.wr_height > H_MAX) ? H_MAX : bus.wr_height;
    wr_top       = (H_MAX - h_clamp) >> 1;
    wr_ent.color = bus.wr_color;
    wr_ent.top   = wr_top;
    wr_ent.bot   = wr_top + h_clamp;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      bank_mem[~active_bank_q][bus.wr_x] <= wr_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_pending_q <= 1'b0;
      active_bank_q  <= 1'b0;
      frame_valid_q  <= 1'b0;
    end else begin
      if (swap_take) begin
        active_bank_q <= ~active_bank_q;
        frame_valid_q <= 1'b1;
      end
      // A request landing on the swap point re-arms for the next frame.
      if (bus.frame_done) begin
        swap_pending_q <= 1'b1;
      end else if (swap_take) begin
        swap_pending_q <= 1'b0;
      end
    end
  end

  // Read pipeline: stage a latches coordinates, stage b holds the bank read,
  // the output register holds the shaded colour.
  logic       a_vld, a_vis;
  logic [9:0] a_x;
  logic [8:0] a_y;
  logic       b_vld, b_vis;
  logic [9:0] b_x;
  logic [8:0] b_y;
  col_t       b_ent;
  logic [8:0] rd_idx;
  logic [3:0] r_q, g_q, b_q;
  logic [3:0] sh_r, sh_g, sh_b;
  logic       crosshair;

  // Off-screen columns read entry 0; the result is masked by the visible flag.
  assign rd_idx = a_vis ? a_x[8:0] : 9'd0;

  always_comb begin
    crosshair = bus.shooting && (b_x > 10'd140) && (b_x < 10'd180)
                && (b_y > 9'd100) && (b_y < 9'd140);
    {sh_r, sh_g, sh_b} = 12'h000;
    if (b_vld && b_vis && frame_valid_q) begin
      if (crosshair) begin
        {sh_r, sh_g, sh_b} = 12'hF00;
      end else if (b_y < {1'b0, b_ent.top}) begin
        {sh_r, sh_g, sh_b} = 12'h333;
      end else if (b_y > {1'b0, b_ent.bot}) begin
        {sh_r, sh_g, sh_b} = 12'h777;
      end else begin
        case (b_ent.color)
          4'd1:    {sh_r, sh_g, sh_b} = 12'h109;
          4'd2:    {sh_r, sh_g, sh_b} = 12'hB14;
          4'd4:    {sh_r, sh_g, sh_b} = 12'h010;
          default: {sh_r, sh_g, sh_b} = 12'h101;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld <= 1'b0;
      a_vis <= 1'b0;
      a_x   <= '0;
      a_y   <= '0;
      b_vld <= 1'b0;
      b_vis <= 1'b0;
      b_x   <= '0;
      b_y   <= '0;
      b_ent <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else if (bus.pix_stb) begin
      a_vld <= 1'b1;
      a_vis <= (bus.x < X_LIM) && (bus.y < Y_LIM);
      a_x   <= bus.x;
      a_y   <= bus.y;
      b_vld <= a_vld;
      b_vis <= a_vis;
      b_x   <= a_x;
      b_y   <= a_y;
      b_ent <= bank_mem[active_bank_q][rd_idx];
      r_q   <= sh_r;
      g_q   <= sh_g;
      b_q   <= sh_b;
    end
  end

  assign bus.swap_pending = swap_pending_q;
  assign bus.active_bank  = active_bank_q;
  assign bus.vga_r        = r_q;
  assign bus.vga_g        = g_q;
  assign bus.vga_b        = b_q;

endmodule
